uart_alu_requester: RTL
=======================

// Module: uart_alu_requester
// PURPOSE
//   Host-side initiator for the UART ALU command protocol. On a one-cycle start
//   request it latches operands A, B and the opcode, serialises them as three
//   UART bytes (A, B, {2'b00,op}), then collects the three-byte reply (result,
//   flags, status 0x55). Used by the board-to-board bench and the loopback top.
// PARAMETERS
//   CLK_FREQ        100_000_000  system clock frequency, Hz
//   BAUD_RATE       9600         UART baud; tick divisor = CLK_FREQ/(BAUD_RATE*16)
//   DATA_BITS       8            operand/result width (protocol fixed at 8)
//   TIMEOUT_CYCLES  2_000_000    reply timeout, clk cycles (only with UART_ALU_REQ_TIMEOUT_EN)
// PORTS
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high
//   i_start      in   1  request pulse; accepted only when o_busy=0
//   i_data_a     in   8  operand A
//   i_data_b     in   8  operand B
//   i_op         in   6  ALU opcode
//   rx           in   1  UART serial in (from ALU board tx)
//   tx           out  1  UART serial out (to ALU board rx); idle high
//   o_busy       out  1  high from the cycle after accept until o_done
//   o_done       out  1  one-cycle pulse; reply outputs valid from this cycle
//   o_result     out  8  received result byte
//   o_zero       out  1  flags byte bit 7
//   o_overflow   out  1  flags byte bit 6
//   o_carry      out  1  flags byte bit 5
//   o_error      out  1  set with o_done: status!=0x55 or timeout
// BEHAVIOUR
//   - Instantiates baud_rate_generator, uart_tx, uart_rx (DBIT=8, SB_TICK=16).
//   - Reset (async): FSM=IDLE; o_busy=0, o_done=0, o_error=0, o_result=0,
//     flags=0, operand regs=0, tx_start=0, timeout counter=0; tx idles high.
//     Reset mid-frame aborts the transfer; no partial byte is resumed.
//   - FSM: IDLE -> SEND_A_ST -> SEND_A_WT -> SEND_B_ST -> SEND_B_WT -> SEND_OP_ST
//     -> SEND_OP_WT -> RECV_RES -> RECV_FLG -> RECV_STA -> DONE -> IDLE.
//   - IDLE: i_start=1 latches i_data_a/i_data_b/i_op same edge, go SEND_A_ST.
//   - *_ST: tx_start=1 for exactly that one cycle, din = selected byte; next *_WT.
//   - *_WT: hold din stable; advance on uart_tx tx_done_tick.
//   - RECV_RES/FLG/STA: on rx_done_tick capture dout into result / flags /
//     status register and advance. Bytes arriving in IDLE or SEND_* are dropped.
//   - DONE (1 cycle): o_done=1; o_error=(status!=8'h55); o_busy=0 next cycle.
//   - Reply outputs and o_error hold until the next DONE or reset.
//   - i_start while o_busy=1 is ignored (no queueing). i_start in DONE ignored.
//   - o_zero/o_overflow/o_carry = flags[7]/[6]/[5]; flags[4:0] ignored.
// CONFIGURATION
//   UART_ALU_REQ_TIMEOUT_EN defined: counter clears on entry to RECV_RES and on
//   each rx_done_tick in RECV_*; increments each cycle in RECV_*; reaching
//   TIMEOUT_CYCLES-1 forces DONE with o_error=1, missing bytes read as 0x00.
//   Undefined: no counter; RECV_* wait indefinitely; o_error only on bad status.
// TESTING
//   1 A=0x05,B=0x03,op=0x20, pulse start -> tx bytes 0x05,0x03,0x20 in order;
//     responder replies 0x08,0x00,0x55 -> o_done pulse, o_result=0x08, flags 0, o_error=0.
//   2 Reply 0x00,0xA0,0x55 -> o_zero=1, o_overflow=0, o_carry=1, o_error=0.
//   3 Reply 0x12,0x00,0x54 -> o_done pulse with o_error=1, o_result=0x12.
//   4 Second i_start (A=0xFF) during SEND_B_WT -> ignored; tx carries only
//     first command; o_done pulses exactly once.
//   5 Assert reset mid-byte in SEND_A_WT -> o_busy=0 and tx=1 immediately,
//     no o_done; new start afterwards completes normally.
//   6 (TIMEOUT_EN, TIMEOUT_CYCLES=1000) send only result byte -> o_done with
//     o_error=1 1000 cycles after last rx byte; undefined: o_busy stays 1.

Source files
------------

// File: rtl/uart_alu_requester_if.sv
// Command/reply bundle between a host and uart_alu_requester.
// The host drives the master side; the requester is the slave.
interface uart_alu_requester_if;
    logic       i_start;
    logic [7:0] i_data_a;
    logic [7:0] i_data_b;
    logic [5:0] i_op;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_result;
    logic       o_zero;
    logic       o_overflow;
    logic       o_carry;
    logic       o_error;

    modport master (
        output i_start, i_data_a, i_data_b, i_op,
        input  o_busy, o_done, o_result,
        input  o_zero, o_overflow, o_carry, o_error
    );

    modport slave (
        input  i_start, i_data_a, i_data_b, i_op,
        output o_busy, o_done, o_result,
        output o_zero, o_overflow, o_carry, o_error
    );
endinterface

// File: rtl/uart_alu_requester.sv
// UART ALU command initiator: sends A, B, op; collects result, flags, status.
// Define UART_ALU_REQ_TIMEOUT_EN to enable the reply timeout.
module baud_rate_generator #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == W'(DIV - 1));
endmodule

module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] din,
    output logic            tx_done_tick,
    output logic            tx
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        T_IDLE, T_START, T_DATA, T_STOP
    } tx_state_t;

    tx_state_t       state;
    logic [4:0]      s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= T_IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            sh           <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            unique case (state)
                T_IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        state <= T_START;
                        s_cnt <= '0;
                        sh    <= din;
                    end
                end
                T_START: begin
                    tx <= 1'b0;
                    if (s_tick) begin
                        if (s_cnt == 5'd15) begin
                            state <= T_DATA;
                            s_cnt <= '0;
                            n_cnt <= '0;
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                T_DATA: begin
                    tx <= sh[0];
                    if (s_tick) begin
                        if (s_cnt == 5'd15) begin
                            s_cnt <= '0;
                            sh    <= sh >> 1;
                            if (n_cnt == NW'(DBIT - 1)) begin
                                state <= T_STOP;
                            end else begin
                                n_cnt <= n_cnt + NW'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                T_STOP: begin
                    tx <= 1'b1;
                    if (s_tick) begin
                        if (s_cnt == 5'(SB_TICK - 1)) begin
                            state        <= T_IDLE;
                            tx_done_tick <= 1'b1;
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                default: state <= T_IDLE;
            endcase
        end
    end
endmodule

module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        R_IDLE, R_START, R_DATA, R_STOP
    } rx_state_t;

    rx_state_t       state;
    logic [4:0]      s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= R_IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            sh           <= '0;
            rx_done_tick <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            unique case (state)
                R_IDLE: begin
                    if (!rx) begin
                        state <= R_START;
                        s_cnt <= '0;
                    end
                end
                // Re-check the start bit at its midpoint to reject glitches.
                R_START: begin
                    if (s_tick) begin
                        if (s_cnt == 5'd7) begin
                            s_cnt <= '0;
                            n_cnt <= '0;
                            state <= rx ? R_IDLE : R_DATA;
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                R_DATA: begin
                    if (s_tick) begin
                        if (s_cnt == 5'd15) begin
                            s_cnt <= '0;
                            sh    <= {rx, sh[DBIT-1:1]};
                            if (n_cnt == NW'(DBIT - 1)) begin
                                state <= R_STOP;
                            end else begin
                                n_cnt <= n_cnt + NW'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                R_STOP: begin
                    if (s_tick) begin
                        if (s_cnt == 5'(SB_TICK - 1)) begin
                            state        <= R_IDLE;
                            rx_done_tick <= 1'b1;
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

    assign dout = sh;
endmodule

module uart_alu_requester #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_alu_requester_if.slave        bus,
    input  logic                       rx,
    output logic                       tx
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);

    if (DATA_BITS != 8 || DIV < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("uart_alu_requester: unsupported parameters");
    end

    typedef enum logic [3:0] {
        IDLE,
        SEND_A_ST, SEND_A_WT,
        SEND_B_ST, SEND_B_WT,
        SEND_OP_ST, SEND_OP_WT,
        RECV_RES, RECV_FLG, RECV_STA,
        DONE
    } state_t;

    state_t               state;
    logic                 s_tick;
    logic                 tx_start;
    logic                 tx_done;
    logic                 rx_done;
    logic                 rx_s1;
    logic                 rx_s2;
    logic [DATA_BITS-1:0] din;
    logic [DATA_BITS-1:0] rx_dout;
    logic [7:0]           a_q;
    logic [7:0]           b_q;
    logic [5:0]           op_q;
    logic [7:0]           res_q;
    logic [2:0]           flg_q;
    logic [7:0]           result_q;
    logic [2:0]           flags_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 in_recv;
    logic                 tmo_hit;

    baud_rate_generator #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .reset(reset),
        .tick (s_tick)
    );

    uart_tx #(.DBIT(DATA_BITS), .SB_TICK(16)) u_tx (
        .clk         (clk),
        .reset       (reset),
        .tx_start    (tx_start),
        .s_tick      (s_tick),
        .din         (din),
        .tx_done_tick(tx_done),
        .tx          (tx)
    );

    uart_rx #(.DBIT(DATA_BITS), .SB_TICK(16)) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx_s2),
        .s_tick      (s_tick),
        .rx_done_tick(rx_done),
        .dout        (rx_dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    assign in_recv = state inside {RECV_RES, RECV_FLG, RECV_STA};

`ifdef UART_ALU_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if ((state == SEND_OP_WT && tx_done) ||
                     (in_recv && rx_done)) begin
            tmo_cnt <= '0;
        end else if (in_recv) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit = in_recv && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            din      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            // A missing byte keeps the zero it was cleared to.
            if (tmo_hit && !rx_done) begin
                result_q <= res_q;
                flags_q  <= flg_q;
                error_q  <= 1'b1;
                done_q   <= 1'b1;
                state    <= DONE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.i_start) begin
                            a_q      <= bus.i_data_a;
                            b_q      <= bus.i_data_b;
                            op_q     <= bus.i_op;
                            din      <= bus.i_data_a;
                            tx_start <= 1'b1;
                            busy_q   <= 1'b1;
                            state    <= SEND_A_ST;
                        end
                    end
                    SEND_A_ST: state <= SEND_A_WT;
                    SEND_A_WT: begin
                        if (tx_done) begin
                            din      <= b_q;
                            tx_start <= 1'b1;
                            state    <= SEND_B_ST;
                        end
                    end
                    SEND_B_ST: state <= SEND_B_WT;
                    SEND_B_WT: begin
                        if (tx_done) begin
                            din      <= {2'b00, op_q};
                            tx_start <= 1'b1;
                            state    <= SEND_OP_ST;
                        end
                    end
                    SEND_OP_ST: state <= SEND_OP_WT;
                    SEND_OP_WT: begin
                        if (tx_done) begin
                            res_q <= '0;
                            flg_q <= '0;
                            state <= RECV_RES;
                        end
                    end
                    RECV_RES: begin
                        if (rx_done) begin
                            res_q <= rx_dout;
                            state <= RECV_FLG;
                        end
                    end
                    RECV_FLG: begin
                        if (rx_done) begin
                            flg_q <= rx_dout[7:5];
                            state <= RECV_STA;
                        end
                    end
                    RECV_STA: begin
                        if (rx_done) begin
                            result_q <= res_q;
                            flags_q  <= flg_q;
                            error_q  <= (rx_dout != 8'h55);
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE: begin
                        done_q <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_result   = result_q;
    assign bus.o_zero     = flags_q[2];
    assign bus.o_overflow = flags_q[1];
    assign bus.o_carry    = flags_q[0];
    assign bus.o_error    = error_q;
endmodule
